// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult
// Radix-4 Booth sequential multiplier. Accepts an operand pair over a
// valid/ready handshake and retires one recoded multiplier digit per clock.
// The WIDTH x WIDTH product is returned over a second valid/ready
// handshake, so the consumer may apply back-pressure.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     operand pair presented by the source
//   in_ready     block can accept operands (IDLE, or DONE while out_ready=1)
//   op_a         multiplicand (WIDTH bits)
//   op_b         multiplier   (WIDTH bits)
//   signed_mode  1 = both operands two's complement, 0 = both unsigned
//   out_valid    product valid (DONE state)
//   out_ready    consumer accepts the product
//   product      full 2*WIDTH-bit product, held until the next result
//   busy         high while iterating (CALC state)
//
// WIDTH must be even and at least 4.
module booth_r4_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  // Number of radix-4 digits needed to cover the (WIDTH+2)-bit extended multiplier.
  localparam int N  = WIDTH / 2 + 1;
  // Extended operand width: two guard bits make unsigned operands positive.
  localparam int EW = WIDTH + 2;
  // Accumulator width: room for acc + 2M without overflow.
  localparam int AW = WIDTH + 4;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [EW-1:0]        mcand_q;
  logic [EW-1:0]        mplier_q, mplier_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [EW-1:0]        ext_a_s, ext_b_s;
  logic [AW-1:0]        pp_s, sum_s;
  logic [AW+EW-1:0]     full_s;
  logic                 accept_s;
  logic                 last_step_s;
  logic                 unused_s;

  // Partial product selected by one Booth group {b(2i+1), b(2i), b(2i-1)}.
  function automatic logic [AW-1:0] booth_pp(input logic [2:0] grp, input logic [EW-1:0] m);
    logic [AW-1:0] m1;
    logic [AW-1:0] m2;
    m1 = {{2{m[EW-1]}}, m};
    m2 = {m[EW-1], m, 1'b0};
    case (grp)
      3'b001, 3'b010: booth_pp = m1;
      3'b011:         booth_pp = m2;
      3'b100:         booth_pp = ~m2 + AW'(1);
      3'b101, 3'b110: booth_pp = ~m1 + AW'(1);
      default:        booth_pp = '0;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = CALC;
        else          state_d = IDLE;
      end
      CALC: begin
        if (last_step_s) state_d = DONE;
        else             state_d = CALC;
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) state_d = CALC;
          else          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      CALC: busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        // A new pair may only enter in the same edge the result leaves.
        in_ready  = out_ready;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Operand extension and one Booth step (add partial product, shift right by 2).
  always_comb begin
    if (signed_mode) begin
      ext_a_s = {{2{op_a[WIDTH-1]}}, op_a};
      ext_b_s = {{2{op_b[WIDTH-1]}}, op_b};
    end else begin
      ext_a_s = {2'b00, op_a};
      ext_b_s = {2'b00, op_b};
    end
    pp_s     = booth_pp({mplier_q[1:0], qm1_q}, mcand_q);
    sum_s    = acc_q + pp_s;
    // {acc, mplier, q-1} is treated as one register shifted arithmetically.
    acc_d    = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
    mplier_d = {sum_s[1:0], mplier_q[EW-1:2]};
    qm1_d    = mplier_q[1];
    full_s   = {acc_d, mplier_d};
  end

  assign accept_s    = in_valid && in_ready;
  assign last_step_s = (state_q == CALC) && (cnt_q == CW'(N - 1));
  // The top guard bits of the exact result are always sign copies.
  assign unused_s    = ^full_s[AW+EW-1:2*WIDTH];

  // Datapath registers: load on accept, iterate in CALC, capture product on the last step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (accept_s) begin
      mcand_q  <= ext_a_s;
      mplier_q <= ext_b_s;
      acc_q    <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == CALC) begin
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_q + CW'(1);
      if (last_step_s) begin
        product_q <= full_s[2*WIDTH-1:0];
      end
    end
  end

  assign product = product_q;

endmodule

// File: doc/booth_r4_seq_mult.md
Name: booth_r4_seq_mult

Overview:
- Parametrised radix-4 Booth sequential multiplier; next generation of the 32x32 shift/accumulate signed multiplier (integrationMult).
- Generic even WIDTH; per-transaction signed/unsigned mode; valid/ready handshakes on input and output; roughly half the iteration count of radix-2.
- Sits between an operand source (register file / ALU issue stage) and a result consumer that may apply back-pressure.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  operand pair presented
in_ready  output  1  block can accept operands
op_a  input  WIDTH  multiplicand
op_b  input  WIDTH  multiplier
signed_mode  input  1  1 = both operands two's complement; 0 = both unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  full-width product
busy  output  1  high in CALC state

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; in_ready=1; out_valid=0; busy=0; product=0; all internal registers cleared. Reset mid-CALC or mid-DONE aborts the operation; nothing is output after release.
- Iterations: N = WIDTH/2 + 1 (17 for WIDTH=32).
- FSM states IDLE, CALC, DONE:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch op_a, op_b, signed_mode; go to CALC; iteration counter=0.
  - CALC: in_ready=0, busy=1. One radix-4 Booth step per cycle. After step N-1 completes, go to DONE.
  - DONE: out_valid=1; product held stable. On out_ready: if in_valid is also high, accept new operands (in_ready=1 in DONE only while out_ready=1) and go directly to CALC; otherwise go to IDLE.
- Latency: out_valid rises at the Nth rising edge after the accepting edge. Back-to-back throughput is one result per N+1 cycles.
- Arithmetic:
  - Operands are extended internally to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended if 0.
  - Multiplier recoded in overlapping 3-bit groups with implicit 0 below the LSB; digits in {-2,-1,0,+1,+2}.
  - Partial products: 0, +/-M, +/-2M, with two's-complement negation. Accumulator arithmetic-shifts right by 2 each step.
  - product = low 2*WIDTH bits of the exact result; no overflow is possible.
- Operand inputs are ignored outside the accept handshake; changing op_a/op_b during CALC does not affect the result.
- product keeps its last value in IDLE; it changes only on entry to DONE or on reset.
- in_valid high while in_ready=0 is held by the source; the block never drops it.
- X-free outputs after reset for all states.

Test Plan:
- WIDTH=32, signed: 0x00087234 x 0x00000348 -> product 0x000000001BB6BAA0; out_valid exactly 17 edges after accept.
- WIDTH=32, signed: 0x00087234 x 0xFFFFFEFD -> 0xFFFFFFFFF7747564. Signed 0x80000000 x 0x80000000 -> 0x4000000000000000. Signed 0xFFFFFFFF x 0xFFFFFFFF -> 0x0000000000000001.
- WIDTH=32, unsigned: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE00000001. Unsigned 0x00000000 x 0x50647236 -> 0x0.
- WIDTH=8: signed 0x80 x 0x7F -> 0xC080; unsigned 0x80 x 0x7F -> 0x3F80; latency 5 edges.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> product/out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 in the same cycle -> new operands accepted that edge; next out_valid 17 edges later.
- Reset mid-operation: drive reset=0 asynchronously at CALC iteration 5 -> out_valid=0, busy=0, product=0 immediately. After release, in_ready=1 and no stale result appears.
